// File: rtl/seq_hit_logger.sv
// Timestamps rising edges of the 11011 detector output and queues the stamps
// in a show-ahead FIFO, with a saturating hit counter and sticky overflow flag.
module seq_hit_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     det_in,
  output logic [TS_W-1:0]          ts_data,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         hit_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0] ts_cnt;
  logic            det_q;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [TS_W-1:0] mem [DEPTH];

  logic hit;
  logic empty;
  logic full;
  logic pop;
  logic push;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign hit      = det_in & ~det_q & en & ~clr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = ~empty & ts_ready & ~clr;
  assign push     = hit & (~full | pop);

  assign ts_valid   = ~empty;
  assign fifo_level = wr_ptr - rd_ptr;
  assign ts_data    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Capture stage: edge detect, counters and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt    <= '0;
      det_q     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      det_q <= det_in;
      if (clr) begin
        ts_cnt    <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        hit_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (en)   ts_cnt <= ts_cnt + TS_W'(1);
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        if (hit) begin
          hit_count <= sat_inc(hit_count);
          if (full && !pop) overflow <= 1'b1;
        end
      end
    end
  end

  // Storage stage: stamp written at the tail, read combinationally at the head
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ts_cnt;
  end

endmodule

// File: doc/seq_hit_logger.md
# seq_hit_logger

Downstream consumer of the 11011 sequence detector. Samples the detector's `out` level, turns each detection into one event, and stamps it with a free-running cycle count. Stores the stamps in a show-ahead FIFO that is drained with a valid/ready handshake. Keeps a saturating hit counter and a sticky overflow flag for the status path.

## Interface
- `TS_W`, 16, timestamp counter width.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `CNT_W`, 8, hit counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `en`  in  1  enables timestamp counting and event capture.
- `clr`  in  1  synchronous clear, active-high.
- `det_in`  in  1  detector output level (Moore `out`).
- `ts_data`  out  TS_W  timestamp at FIFO head.
- `ts_valid`  out  1  FIFO non-empty.
- `ts_ready`  in  1  consumer accepts head this cycle.
- `fifo_level`  out  $clog2(DEPTH)+1  entries stored.
- `hit_count`  out  CNT_W  events seen since reset/clear, saturating.
- `overflow`  out  1  sticky: at least one event dropped on full FIFO.

## Operation
- **Timestamp counter `ts_cnt` (TS_W bits):**
  - Increments by 1 each cycle with `en`=1; holds when `en`=0.
  - Wraps from 2^TS_W−1 to 0.
- **Edge register:** `det_q` samples `det_in` every cycle, regardless of `en`/`clr`.
- **Event:** `det_in`=1 & `det_q`=0 & `en`=1 & `clr`=0.
  - A level held high for N cycles is one event.
  - A new event needs `det_in` to return low first.
- **Event capture:** the event stamp is the `ts_cnt` register value in the event cycle, before its increment.
- **Push:**
  - If the FIFO is not full, the stamp is written at the write pointer.
  - If the FIFO is full, the stamp is dropped and `overflow` is set to 1; it stays set until `clr` or reset.
- **Hit counter:** `hit_count` increments on every event, including dropped ones, and saturates at 2^CNT_W−1.
- **FIFO:**
  - Show-ahead: `ts_data` = head entry whenever `ts_valid`=1.
  - `ts_data` is don't-care when empty; the implementation drives 0.
  - Pop occurs at the rising edge where `ts_valid` & `ts_ready`.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- **Simultaneous push and pop, full:** the pop frees a slot, so the push is accepted. Level stays DEPTH and `overflow` is not set.
- **Simultaneous push and pop, non-full and non-empty:** level unchanged.
- **Push when empty:** no pop is possible because `ts_valid`=0. The entry becomes visible next cycle.
- **`clr` (priority over push/pop/count):**
  - Empties the FIFO and zeroes `ts_cnt`, `hit_count` and `overflow`.
  - An event in the `clr` cycle is discarded.
- **`en`=0:** events are ignored, but FIFO reads continue normally.

## Timing
- Reset (`rst`=0, asynchronous) forces `ts_cnt`, `det_q`, pointers, `hit_count` and `overflow` to 0. All outputs read 0 while reset is asserted.
- Reset takes effect immediately mid-operation; FIFO contents are lost.
- First rising edge after `rst` deasserts with `en`=1 is cycle 0. `det_in` first high in cycle k gives stamp k, modulo 2^TS_W.
- **Event-to-output latency:** 1 cycle. `ts_valid`, `fifo_level` and `hit_count` update at the edge ending the event cycle.
- **Pop latency:** `ts_data`/`fifo_level` show the next entry the cycle after the accepting edge. With `ts_ready` held at 1, one entry drains per cycle.
- `overflow` asserts at the edge ending the dropped-event cycle.
- All outputs are registered or direct decodes of registers (`ts_data` is a memory read at the head pointer). There is no combinational path from `det_in` to any output.
- Detector cadence: a non-overlapping 11011 detector produces events at least 5 cycles apart. The logger accepts events as close as every 2 cycles (high, low, high).

## Test plan
- **Reset:** hold `rst`=0 with `det_in` toggling → `ts_valid`=0, `fifo_level`=0, `hit_count`=0, `overflow`=0. Then assert `rst`=0 mid-run with 3 entries stored → all of these return to 0 immediately.
- **Basic capture:** `en`=1, `ts_ready`=0, `det_in` pulses high in cycles 3 and 10 → `fifo_level`=2, `hit_count`=2, `ts_data`=3. After one pop, `ts_data`=10; after a second pop, `ts_valid`=0.
- **Level and upstream chain:** `det_in` held high cycles 5–8 → exactly one entry, stamp 5. Separately, feed the detector bitstream 1101111011 through a detector instance into `det_in` → 2 entries.
- **Overflow:** `DEPTH`=8, 10 pulses spaced 2 cycles apart starting cycle 0, `ts_ready`=0 → `fifo_level`=8, `hit_count`=10, `overflow`=1, drained stamps 0,2,…,14.
- **Full with pop and push together:** FIFO full, `ts_ready`=1 in the same cycle as an event → `fifo_level` stays 8, `overflow`=0, new stamp lands at the tail.
- **Wrap, `en` and `clr`:**
  - `TS_W`=4: event in cycle 17 → stamp 1.
  - `en`=0 for cycles 4–6 with a pulse at 5 → no entry, and later stamps shifted by 3.
  - `clr` coincident with a pulse and a non-empty FIFO → `fifo_level`=0, `hit_count`=0, `overflow`=0, no entry.
